// File: rtl/mtr_pkg.sv
// ---------------------------------------------------------------------------
// mtr_pkg
// Shared types and constants for the motor duty-ramp path.
//   spd_t        : signed 11-bit motor speed, -1024..+1023
//   duty_t       : unsigned 11-bit PWM duty word
//   DUTY_MID     : duty word for zero speed (50 %)
//   ramp_state_t : TRACK (following the target) / HOLD (zero-speed dwell)
//   DUTY_SAT_LO/HI : duty limits used when MTR_DUTY_SAT_EN is defined
// No ports.
// ---------------------------------------------------------------------------
package mtr_pkg;

  typedef logic signed [10:0] spd_t;
  typedef logic        [10:0] duty_t;

  localparam duty_t DUTY_MID    = 11'h400;
  localparam duty_t DUTY_SAT_LO = 11'd64;
  localparam duty_t DUTY_SAT_HI = 11'd1983;

  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } ramp_state_t;

endpackage

// File: rtl/mtr_tick_gen.sv
// ---------------------------------------------------------------------------
// mtr_tick_gen
// Free-running 0..TICK_DIV-1 counter that produces a one-cycle tick pulse
// on the cycle where the count equals TICK_DIV-1. After reset the first
// tick-qualified clock edge is edge number TICK_DIV.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset (count restarts from 0)
//   tick  : one-cycle pulse, high while count == TICK_DIV-1
// ---------------------------------------------------------------------------
module mtr_tick_gen #(
  parameter int unsigned TICK_DIV = 2048
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mtr_duty_ramp.sv
// ---------------------------------------------------------------------------
// mtr_duty_ramp
// Converts a signed speed command into the unsigned duty word for the PWM.
// Speed is slew-limited by STEP per update tick, and a zero-speed dwell of
// ZERO_HOLD ticks is forced before any change of direction.
//
// Optional build macro: MTR_DUTY_SAT_EN
//   defined   : duty clamped to DUTY_SAT_LO..DUTY_SAT_HI (keeps bootstrap
//               gate drivers charged); speed and at_tgt unaffected
//   undefined : full duty range 0..2047
//
// Ports:
//   clk      : system clock
//   rst_n    : synchronous active-low reset
//   en       : 1 = track spd_tgt, 0 = effective target is 0
//   spd_tgt  : signed target speed, -1024..+1023
//   duty     : registered duty word = speed + 0x400
//   at_tgt   : registered, speed equals the target sampled on last tick
//   rev_hold : registered, high during the zero-speed reversal dwell
// ---------------------------------------------------------------------------
module mtr_duty_ramp
  import mtr_pkg::*;
#(
  parameter int unsigned STEP      = 8,
  parameter int unsigned TICK_DIV  = 2048,
  parameter int unsigned ZERO_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic signed [10:0] spd_tgt,
  output logic        [10:0] duty,
  output logic               at_tgt,
  output logic               rev_hold
);

  localparam int HOLD_W = $clog2(ZERO_HOLD + 1);

  localparam logic signed [11:0] STEP_W   = 12'(STEP);
  localparam spd_t               STEP_SPD = spd_t'(STEP);

  // Move cur one STEP toward tgt, landing exactly on tgt when within reach.
  // The difference is taken in 12 bits so -1024 to +1023 cannot overflow.
  function automatic spd_t step_toward(spd_t cur, spd_t tgt);
    logic signed [11:0] diff;
    diff = $signed({tgt[10], tgt}) - $signed({cur[10], cur});
    if ((diff >= -STEP_W) && (diff <= STEP_W)) begin
      return tgt;
    end else if (diff > 12'sd0) begin
      return cur + STEP_SPD;
    end else begin
      return cur - STEP_SPD;
    end
  endfunction

  function automatic duty_t sat_duty(duty_t d);
`ifdef MTR_DUTY_SAT_EN
    if (d < DUTY_SAT_LO) begin
      return DUTY_SAT_LO;
    end else if (d > DUTY_SAT_HI) begin
      return DUTY_SAT_HI;
    end else begin
      return d;
    end
`else
    return d;
`endif
  endfunction

  logic              vld_p0;
  spd_t              eff_tgt_p0;
  logic              rev_pend_p0;
  spd_t              nxt_spd_p0;
  ramp_state_t       nxt_state_p0;
  logic [HOLD_W-1:0] nxt_hold_p0;

  spd_t              cur_spd_p1;
  ramp_state_t       state_p1;
  logic [HOLD_W-1:0] hold_cnt_p1;

  mtr_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (vld_p0)
  );

  // Stage p0: effective target, reversal detection and next speed/state
  always_comb begin
    eff_tgt_p0   = en ? spd_tgt : '0;
    rev_pend_p0  = (cur_spd_p1 != '0) && (eff_tgt_p0 != '0) &&
                   (cur_spd_p1[10] != eff_tgt_p0[10]);
    nxt_spd_p0   = cur_spd_p1;
    nxt_state_p0 = state_p1;
    nxt_hold_p0  = hold_cnt_p1;
    case (state_p1)
      TRACK: begin
        if (rev_pend_p0) begin
          // Brake toward zero first; the dwell starts once zero is reached.
          nxt_spd_p0 = step_toward(cur_spd_p1, '0);
          if (nxt_spd_p0 == '0) begin
            nxt_state_p0 = HOLD;
            nxt_hold_p0  = HOLD_W'(ZERO_HOLD);
          end
        end else begin
          nxt_spd_p0 = step_toward(cur_spd_p1, eff_tgt_p0);
        end
      end
      HOLD: begin
        // Dwell length is fixed: en or target changes do not shorten it.
        nxt_spd_p0  = '0;
        nxt_hold_p0 = hold_cnt_p1 - HOLD_W'(1);
        if (nxt_hold_p0 == '0) begin
          nxt_state_p0 = TRACK;
        end
      end
      default: begin
        nxt_state_p0 = TRACK;
      end
    endcase
  end

  // Stage p1: speed, state and outputs registered together on each tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_spd_p1  <= '0;
      state_p1    <= TRACK;
      hold_cnt_p1 <= '0;
      duty        <= DUTY_MID;
      at_tgt      <= 1'b0;
      rev_hold    <= 1'b0;
    end else if (vld_p0) begin
      cur_spd_p1  <= nxt_spd_p0;
      state_p1    <= nxt_state_p0;
      hold_cnt_p1 <= nxt_hold_p0;
      duty        <= sat_duty(duty_t'(nxt_spd_p0) + DUTY_MID);
      at_tgt      <= (nxt_spd_p0 == eff_tgt_p0);
      rev_hold    <= (nxt_state_p0 == HOLD);
    end
  end

endmodule

// File: tb/tb_mtr_duty_ramp.sv
// ---------------------------------------------------------------------------
// tb_mtr_duty_ramp
// Scoreboard bench for mtr_duty_ramp with TICK_DIV=4, STEP=8, ZERO_HOLD=2.
// Expected {duty, at_tgt, rev_hold} per tick are queued when the stimulus
// is applied and compared one tick at a time; outputs are also checked to
// hold steady on the cycle before each tick.
// ---------------------------------------------------------------------------
module tb_mtr_duty_ramp;

  localparam int TDIV = 4;

  typedef struct packed {
    logic [10:0] duty;
    logic        at;
    logic        rev;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic signed [10:0] spd_tgt;
  logic        [10:0] duty;
  logic               at_tgt;
  logic               rev_hold;
  logic        [12:0] obs;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t e;
  exp_t last;

  assign obs = {duty, at_tgt, rev_hold};

  mtr_duty_ramp #(
    .STEP      (8),
    .TICK_DIV  (TDIV),
    .ZERO_HOLD (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .spd_tgt  (spd_tgt),
    .duty     (duty),
    .at_tgt   (at_tgt),
    .rev_hold (rev_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(int spd, bit at, bit rev);
    int   d;
    exp_t r;
    d = spd + 1024;
`ifdef MTR_DUTY_SAT_EN
    if (d < 64)   d = 64;
    if (d > 1983) d = 1983;
`endif
    r.duty = d[10:0];
    r.at   = at;
    r.rev  = rev;
    return r;
  endfunction

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_edges(2);
    rst_n = 1'b1;
    last = mk(0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    en      = 1'b1;
    spd_tgt = 11'sd100;
    rst_n   = 1'b0;
    wait_edges(2);
    checks++;
    if (duty !== 11'h400) begin
      failures++;
      $display("FAIL reset_duty: got %h want 400", duty);
    end
    checks++;
    if (at_tgt !== 1'b0) begin
      failures++;
      $display("FAIL reset_at_tgt: got %b want 0", at_tgt);
    end
    checks++;
    if (rev_hold !== 1'b0) begin
      failures++;
      $display("FAIL reset_rev_hold: got %b want 0", rev_hold);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_edges(1);
      checks++;
      if (duty !== 11'h400) begin
        failures++;
        $display("FAIL reset_release_edge%0d: got duty=%h want 400", i, duty);
      end
    end
    sb.push_back(mk(8, 1'b0, 1'b0));
    wait_edges(1);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset_first_tick: got duty=%h at=%b rev=%b want duty=%h at=%b rev=%b",
               obs[12:2], obs[1], obs[0], e.duty, e.at, e.rev);
    end
  endtask

  task automatic test_ramp_up();
    do_reset();
    en      = 1'b1;
    spd_tgt = 11'sd20;
    sb.push_back(mk(8,  1'b0, 1'b0));
    sb.push_back(mk(16, 1'b0, 1'b0));
    sb.push_back(mk(20, 1'b1, 1'b0));
    sb.push_back(mk(20, 1'b1, 1'b0));
    sb.push_back(mk(20, 1'b1, 1'b0));
    for (int t = 1; sb.size() != 0; t++) begin
      wait_edges(TDIV - 1);
      checks++;
      if (obs !== last) begin
        failures++;
        $display("FAIL ramp_up_hold%0d: got %h want %h", t, obs, last);
      end
      wait_edges(1);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL ramp_up_tick%0d: got duty=%h at=%b rev=%b want duty=%h at=%b rev=%b",
                 t, obs[12:2], obs[1], obs[0], e.duty, e.at, e.rev);
      end
      last = e;
    end
  endtask

  // Continues from +20 left by test_ramp_up.
  task automatic test_reversal();
    spd_tgt = -11'sd10;
    sb.push_back(mk(12,  1'b0, 1'b0));
    sb.push_back(mk(4,   1'b0, 1'b0));
    sb.push_back(mk(0,   1'b0, 1'b1));
    sb.push_back(mk(0,   1'b0, 1'b1));
    sb.push_back(mk(0,   1'b0, 1'b0));
    sb.push_back(mk(-8,  1'b0, 1'b0));
    sb.push_back(mk(-10, 1'b1, 1'b0));
    sb.push_back(mk(-10, 1'b1, 1'b0));
    for (int t = 1; sb.size() != 0; t++) begin
      wait_edges(TDIV - 1);
      checks++;
      if (obs !== last) begin
        failures++;
        $display("FAIL reversal_hold%0d: got %h want %h", t, obs, last);
      end
      wait_edges(1);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reversal_tick%0d: got duty=%h at=%b rev=%b want duty=%h at=%b rev=%b",
                 t, obs[12:2], obs[1], obs[0], e.duty, e.at, e.rev);
      end
      last = e;
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    en      = 1'b1;
    spd_tgt = 11'sd100;
    for (int k = 1; k <= 12; k++) sb.push_back(mk(8 * k, 1'b0, 1'b0));
    sb.push_back(mk(100, 1'b1, 1'b0));
    for (int pass = 0; pass < 2; pass++) begin
      for (int t = 1; sb.size() != 0; t++) begin
        wait_edges(TDIV - 1);
        checks++;
        if (obs !== last) begin
          failures++;
          $display("FAIL en_drop_p%0d_hold%0d: got %h want %h", pass, t, obs, last);
        end
        wait_edges(1);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL en_drop_p%0d_tick%0d: got duty=%h at=%b rev=%b want duty=%h at=%b rev=%b",
                   pass, t, obs[12:2], obs[1], obs[0], e.duty, e.at, e.rev);
        end
        last = e;
      end
      if (pass == 0) begin
        en = 1'b0;
        for (int k = 1; k <= 12; k++) sb.push_back(mk(100 - 8 * k, 1'b0, 1'b0));
        sb.push_back(mk(0, 1'b1, 1'b0));
        sb.push_back(mk(0, 1'b1, 1'b0));
      end
    end
  endtask

  task automatic test_saturation();
    for (int dir = 0; dir < 2; dir++) begin
      do_reset();
      en      = 1'b1;
      spd_tgt = (dir == 0) ? -11'sd1024 : 11'sd1023;
      for (int k = 1; k <= 127; k++)
        sb.push_back(mk((dir == 0) ? -8 * k : 8 * k, 1'b0, 1'b0));
      sb.push_back(mk((dir == 0) ? -1024 : 1023, 1'b1, 1'b0));
      sb.push_back(mk((dir == 0) ? -1024 : 1023, 1'b1, 1'b0));
      for (int t = 1; sb.size() != 0; t++) begin
        wait_edges(TDIV - 1);
        checks++;
        if (obs !== last) begin
          failures++;
          $display("FAIL sat_d%0d_hold%0d: got %h want %h", dir, t, obs, last);
        end
        wait_edges(1);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL sat_d%0d_tick%0d: got duty=%h at=%b rev=%b want duty=%h at=%b rev=%b",
                   dir, t, obs[12:2], obs[1], obs[0], e.duty, e.at, e.rev);
        end
        last = e;
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    en      = 1'b1;
    spd_tgt = 11'sd20;
    sb.push_back(mk(8,  1'b0, 1'b0));
    sb.push_back(mk(16, 1'b0, 1'b0));
    sb.push_back(mk(20, 1'b1, 1'b0));
    for (int pass = 0; pass < 3; pass++) begin
      for (int t = 1; sb.size() != 0; t++) begin
        wait_edges(TDIV - 1);
        checks++;
        if (obs !== last) begin
          failures++;
          $display("FAIL mid_rst_p%0d_hold%0d: got %h want %h", pass, t, obs, last);
        end
        wait_edges(1);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL mid_rst_p%0d_tick%0d: got duty=%h at=%b rev=%b want duty=%h at=%b rev=%b",
                   pass, t, obs[12:2], obs[1], obs[0], e.duty, e.at, e.rev);
        end
        last = e;
      end
      if (pass == 0) begin
        spd_tgt = -11'sd10;
        sb.push_back(mk(12, 1'b0, 1'b0));
        sb.push_back(mk(4,  1'b0, 1'b0));
        sb.push_back(mk(0,  1'b0, 1'b1));
      end else if (pass == 1) begin
        // Now in the dwell: pulse reset for one clock mid-period.
        wait_edges(2);
        rst_n = 1'b0;
        wait_edges(1);
        rst_n = 1'b1;
        checks++;
        if (obs !== 13'h1000) begin
          failures++;
          $display("FAIL mid_rst_outputs: got duty=%h at=%b rev=%b want duty=400 at=0 rev=0",
                   obs[12:2], obs[1], obs[0]);
        end
        last = mk(0, 1'b0, 1'b0);
        sb.push_back(mk(-8,  1'b0, 1'b0));
        sb.push_back(mk(-10, 1'b1, 1'b0));
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    spd_tgt = '0;
    last    = mk(0, 1'b0, 1'b0);
    test_reset();
    test_ramp_up();
    test_reversal();
    test_enable_drop();
    test_saturation();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
